// File: rtl/ceu_div_sequencer.sv
// Issues one job of NUM_ELEM double-precision divisions sharing a denominator to the divider
// and gathers the in-order quotients, with zero-divisor flagging and a result watchdog.
module ceu_div_sequencer #(
  parameter int DBL_WIDTH   = 64,
  parameter int NUM_ELEM    = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_ELEM*DBL_WIDTH-1:0] numerators,
  input  logic [DBL_WIDTH-1:0]          denominator,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_ELEM*DBL_WIDTH-1:0] quotients,
  output logic                          div_by_zero,
  output logic                          timeout_err,
  output logic                          div_valid,
  output logic [DBL_WIDTH-1:0]          div_numerator,
  output logic [DBL_WIDTH-1:0]          div_denominator,
  input  logic                          div_finish,
  input  logic [DBL_WIDTH-1:0]          div_quotient
);

  localparam int IDX_W = $clog2(NUM_ELEM + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int VEC_W = NUM_ELEM * DBL_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [VEC_W-1:0]     num_q, num_d;
  logic [VEC_W-1:0]     quot_q, quot_d;
  logic [DBL_WIDTH-1:0] den_q, den_d;
  logic                 dbz_q, dbz_d;
  logic                 tmo_q, tmo_d;
  logic                 dv_q, dv_d;
  logic [DBL_WIDTH-1:0] dnum_q, dnum_d;
  logic [DBL_WIDTH-1:0] dden_q, dden_d;
  logic                 active;
  logic                 capture;
  logic                 wd_run;
  logic                 wd_expire;

  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    rx_idx_d    = rx_idx_q;
    wd_d        = wd_q;
    num_d       = num_q;
    den_d       = den_q;
    quot_d      = quot_q;
    dbz_d       = dbz_q;
    tmo_d       = tmo_q;
    dv_d        = 1'b0;
    dnum_d      = '0;
    dden_d      = '0;

    active    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    capture   = active && div_finish && (rx_idx_q < IDX_W'(NUM_ELEM));
    // The watchdog only runs while at least one issued division is still unanswered.
    wd_run    = active && !div_finish && (issue_idx_q > rx_idx_q);
    wd_expire = wd_run && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    if (active && div_finish) begin
      wd_d = '0;
    end else if (wd_run) begin
      wd_d = wd_q + WD_W'(1);
    end

    if (capture) begin
      rx_idx_d = rx_idx_q + IDX_W'(1);
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (rx_idx_q == IDX_W'(i)) begin
          quot_d[i*DBL_WIDTH +: DBL_WIDTH] = div_quotient;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          num_d       = numerators;
          den_d       = denominator;
          issue_idx_d = '0;
          rx_idx_d    = '0;
          wd_d        = '0;
          tmo_d       = 1'b0;
          dbz_d       = (denominator[DBL_WIDTH-2:0] == '0);
        end
      end
      S_ISSUE: begin
        issue_idx_d = issue_idx_q + IDX_W'(1);
        if (wd_expire) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else if (rx_idx_d == IDX_W'(NUM_ELEM)) begin
          state_d = S_DONE;
        end else if (issue_idx_q == IDX_W'(NUM_ELEM - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wd_expire) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else if (rx_idx_d == IDX_W'(NUM_ELEM)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Divider operands are registered, so they are built from next-state values.
    if (state_d == S_ISSUE) begin
      dv_d   = 1'b1;
      dden_d = den_d;
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (issue_idx_d == IDX_W'(i)) begin
          dnum_d = num_d[i*DBL_WIDTH +: DBL_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_idx_q <= '0;
      rx_idx_q    <= '0;
      wd_q        <= '0;
      num_q       <= '0;
      den_q       <= '0;
      quot_q      <= '0;
      dbz_q       <= 1'b0;
      tmo_q       <= 1'b0;
      dv_q        <= 1'b0;
      dnum_q      <= '0;
      dden_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      rx_idx_q    <= rx_idx_d;
      wd_q        <= wd_d;
      num_q       <= num_d;
      den_q       <= den_d;
      quot_q      <= quot_d;
      dbz_q       <= dbz_d;
      tmo_q       <= tmo_d;
      dv_q        <= dv_d;
      dnum_q      <= dnum_d;
      dden_q      <= dden_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign quotients       = quot_q;
  assign div_by_zero     = dbz_q;
  assign timeout_err     = tmo_q;
  assign div_valid       = dv_q;
  assign div_numerator   = dnum_q;
  assign div_denominator = dden_q;

endmodule

// File: doc/ceu_div_sequencer.md
# ceu_div_sequencer

Initiator-side controller for the CEU floating-point divider wrapper. It accepts one job of NUM_ELEM IEEE-754 double numerators sharing a single denominator (the α of the CEU inverse step), then issues them to the divider one per cycle on its `valid` input. It collects the in-order quotients returned on the divider's `finish` pulses and presents them as one packed result with a single-cycle `done`. It sits between the CEU control logic and the divider wrapper, and adds zero-denominator flagging and a result watchdog.

## Interface
- DBL_WIDTH, 64, operand/result width (IEEE-754 double)
- NUM_ELEM, 3, divisions per job (b, e, y)
- TIMEOUT_CYC, 64, maximum cycles without a `div_finish` while results are outstanding

- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- numerators  in  NUM_ELEM*DBL_WIDTH  packed numerators; element i is at [i*DBL_WIDTH +: DBL_WIDTH]
- denominator  in  DBL_WIDTH  common divisor
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; all quotients are valid
- quotients  out  NUM_ELEM*DBL_WIDTH  packed results, same packing as `numerators`
- div_by_zero  out  1  denominator was ±0 for the current or last job
- timeout_err  out  1  watchdog expired; sticky until the next accepted start
- div_valid  out  1  issue strobe to the divider
- div_numerator  out  DBL_WIDTH  dividend to the divider
- div_denominator  out  DBL_WIDTH  divisor to the divider
- div_finish  in  1  divider result strobe
- div_quotient  in  DBL_WIDTH  divider result

## Operation
- **Reset:**
  - All outputs are 0.
  - State is IDLE.
  - All counters and operand/result registers are cleared.
  - Reset mid-job aborts the job; any later `div_finish` pulses are treated as stray.
- **States and transitions:**
  - IDLE → ISSUE on `start`.
    - `numerators` and `denominator` are latched.
    - Issue index, receive index and watchdog are zeroed.
    - `timeout_err` is cleared.
    - `div_by_zero` is set to (denominator[62:0] == 0); NaN and Inf are not flagged.
  - ISSUE: `div_valid` = 1, `div_numerator` = latched element[issue_idx], `div_denominator` = latched denominator. Issue index increments each cycle. After element NUM_ELEM-1 is issued → DRAIN.
  - DRAIN: wait for the remaining results. When the receive count reaches NUM_ELEM → DONE.
  - DONE: `done` = 1 for exactly one cycle → IDLE.
  - Any state with the watchdog expired → IDLE with `timeout_err` = 1 and no `done`.
- **Result capture:**
  - Active in ISSUE and DRAIN: on `div_finish`, `div_quotient` is written to slot rx_idx and rx_idx increments.
  - Results are in order; the divider accepts every cycle with no backpressure.
  - A finish arriving during ISSUE, including on the last issue cycle, is captured normally. If the final result lands in ISSUE, the FSM goes directly to DONE.
- **Stray finishes:**
  - `div_finish` in IDLE or DONE is ignored; no register changes.
  - Once rx_idx equals NUM_ELEM, further finishes are ignored.
- **Ignored start:** `start` while `busy` is ignored; latched operands stay unchanged.
- **Watchdog:**
  - Counts cycles in ISSUE/DRAIN while issued > received, and resets on every `div_finish`.
  - Expiry at TIMEOUT_CYC consecutive cycles without a finish.
- **Output hold:** `quotients` hold their values from DONE until the next accepted start. Slots are not cleared at start; they are overwritten as results arrive.
- **Width rules:**
  - Index counters are $clog2(NUM_ELEM+1) bits.
  - The watchdog counter is $clog2(TIMEOUT_CYC+1) bits.
  - No arithmetic is performed on the data.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..NUM_ELEM: `div_valid` high, elements issued in order 0..NUM_ELEM-1.
- With divider latency L, finish k arrives at cycle 1+k+L. `done` is high at cycle NUM_ELEM+L+1; `busy` falls in the following cycle.
- For L = 28 and NUM_ELEM = 3: `done` at cycle 32.
- The earliest next start is sampled the cycle after `done`.
- `div_numerator` and `div_denominator` are registered; both are 0 whenever `div_valid` = 0.

## Test plan
- **Nominal job:** numerators {0x4018000000000000 (6.0), 0x4022000000000000 (9.0), 0xC008000000000000 (−3.0)}, denominator 0x4008000000000000 (3.0), bench divider latency 28 → `done` at cycle 32; quotients {0x4000000000000000, 0x4008000000000000, 0xBFF0000000000000}; `div_by_zero` = 0.
- **Zero denominator:** denominator 0x8000000000000000 with the same numerators, bench returns 0x7FF0000000000000 / 0xFFF0000000000000 → `div_by_zero` = 1 and `done` pulses once; the next job with denominator 3.0 clears the flag.
- **Latency 1:** first finish lands during ISSUE → all three captured in order; `done` at cycle 5.
- **Lost result:** bench drops the third result → `timeout_err` = 1 exactly 64 cycles after the second finish; `busy` falls and `done` never pulses.
- **Stray start and finish:** `start` at cycle 10 of a job is ignored and results match the first job. A `div_finish` pulse in IDLE leaves `quotients` unchanged.
- **Reset mid-job:** `rst_n` low at cycle 15 → all outputs 0 immediately. Late finishes are ignored; a new job afterwards completes correctly.
